mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 2K x 16 test memory between two requesters: the stimulus generator (port 0) and the validator (port 1).
- Each cycle it arbitrates between read/write requests using round-robin. It drives one registered memory command per cycle.
- It tracks the owner of each read in flight and routes read data back to that owner with a valid strobe.
- It sits between the requesters and the memory model in the test harness.

Parameters:
- ADDR_WIDTH, 11, memory address width.
- DATA_WIDTH, 16, memory word width.
- PROT_BASE, 11'd1000, first address reserved for results; port 0 may not write at or above it.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 command request; held until granted.
- p0_we  in  1  port 0 command type: 1 = write, 0 = read.
- p0_addr  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_gnt  out  1  port 0 command accepted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid (one-cycle pulse).
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_address  out  ADDR_WIDTH  registered memory address.
- mem_rd_en  out  1  registered memory read enable.
- mem_wr_en  out  1  registered memory write enable.
- mem_data_in  out  DATA_WIDTH  registered memory write data.
- mem_data_out  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd_en.
- prot_err  out  1  sticky flag: a port 0 write to an address >= PROT_BASE was blocked.
- arb_idle  out  1  high when no request is pending and no read is in flight.

Behaviour:
- Reset (async, reset_n=0):
  - All registered outputs go to 0: mem_address, mem_rd_en, mem_wr_en, mem_data_in, pN_rvalid, pN_rdata, prot_err.
  - The in-flight read pipeline is cleared.
  - Round-robin pointer last_gnt is set to 1, so port 0 wins the first contest.
  - pN_gnt is forced to 0 while reset_n=0.
  - Reset mid-transaction discards any outstanding read; no rvalid is ever issued for it.
- Arbitration (combinational, cycle T):
  - Only p0_req: p0_gnt=1.
  - Only p1_req: p1_gnt=1.
  - Both requesting: grant the port != last_gnt.
  - At most one gnt is high per cycle.
  - last_gnt updates to the winner at the end of T. It does not change on an idle cycle.
  - A requester must hold req, we, addr and wdata stable until it sees gnt. It may drop req or issue a new command in the cycle after gnt.
- Command issue (cycle T+1):
  - The winner's command is registered onto mem_*.
  - A read sets mem_rd_en=1 and mem_wr_en=0. A write sets mem_wr_en=1 and mem_rd_en=0.
  - mem_address and mem_data_in hold their last value when no command is issued; only the enables return to 0.
- Write protection:
  - A granted port 0 write with p0_addr >= PROT_BASE is still granted, so the requester is not stalled.
  - No mem_wr_en is issued for it, and prot_err is set at T+1. prot_err stays 1 until reset.
  - Port 1 writes are unrestricted.
- Read return:
  - A 2-stage tag pipeline holds {valid, owner}.
  - mem_data_out is captured at T+2. pOwner_rdata takes it and pOwner_rvalid=1 for one cycle at T+3 (registered).
  - Read latency from gnt to rvalid is 3 cycles.
  - The non-owner's rdata keeps its previous value and its rvalid stays 0.
  - Back-to-back reads on alternating ports return in grant order, one per cycle.
- Throughput: one command per cycle; no bubbles between grants.
- arb_idle = !p0_req && !p1_req && no valid tag in the pipeline and no command register pending. It is registered and reset to 1 after reset release.
- Simultaneous events:
  - A new grant in the same cycle as an earlier read's rvalid is legal.
  - Both ports requesting continuously gives strict alternation 0,1,0,1...

Test Plan:
- Reset then single p1 read of addr 512 (memory holds 16'h1234): p1_gnt at T, mem_rd_en with mem_address=512 at T+1, p1_rvalid=1 with p1_rdata=16'h1234 at T+3; p0_rvalid stays 0.
- p0 and p1 both request reads (addr 5, addr 513) continuously for 4 cycles: grants alternate 0,1,0,1 starting with port 0; rvalids arrive in the same order, each 3 cycles after its grant.
- p1 write addr 1000 data 16'h0003: mem_wr_en=1, mem_address=1000, mem_data_in=16'h0003 at T+1; prot_err stays 0.
- p0 write addr 1000 data 16'hFFFF: p0_gnt=1 but mem_wr_en stays 0 at T+1; prot_err=1 from T+1 and remains 1 for 20 further cycles.
- p1 read granted, then reset_n pulsed low at T+1 for 1 cycle: all outputs 0 immediately; no p1_rvalid ever appears; after release arb_idle=1 and the next contest grants port 0.
- Idle for 10 cycles after a write: mem_rd_en=mem_wr_en=0, arb_idle=1, last_gnt unchanged; verified by the next two-port contest granting the other port first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles for the arbiter: one requester-side command/response port and the
// registered command bus toward the single-port memory.

interface mem_req_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    // Handshake: the requester holds req/we/addr/wdata stable while req is
    // high and gnt is low; the cycle with req && gnt transfers the command.
    // rvalid is a one-cycle pulse qualifying rdata; there is no back-pressure.
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface mem_bus_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output address, rd_en, wr_en, data_in, input data_out);
    modport slave  (input address, rd_en, wr_en, data_in, output data_out);
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two requesters,
// with write protection of the results region for port 0 and read-data routing.

module mem_port_arbiter #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] PROT_BASE  = 11'd1000
) (
    input  logic      clk,
    input  logic      reset_n,
    mem_req_if.slave  p0,
    mem_req_if.slave  p1,
    mem_bus_if.master mem,
    output logic      prot_err,
    output logic      arb_idle
);

    logic                  last_gnt;
    logic                  gnt0;
    logic                  gnt1;
    logic                  any_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  blocked;
    logic                  issue_rd;
    logic                  issue_wr;

    // Read tag pipeline: stage 1 aligns with mem_rd_en, stage 2 with mem_data_out.
    logic                  tag1_v;
    logic                  tag1_owner;
    logic                  tag2_v;
    logic                  tag2_owner;

    // Port 0 wins a contest only when port 1 was the last winner.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (p0.req && (!p1.req || last_gnt)) begin
                gnt0 = 1'b1;
            end else if (p1.req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt0 ? p0.we    : p1.we;
    assign sel_addr  = gnt0 ? p0.addr  : p1.addr;
    assign sel_wdata = gnt0 ? p0.wdata : p1.wdata;

    // A protected write is still granted so port 0 never stalls; it is dropped here.
    assign blocked   = gnt0 && p0.we && (p0.addr >= PROT_BASE);
    assign issue_rd  = any_gnt && !sel_we;
    assign issue_wr  = any_gnt && sel_we && !blocked;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt    <= 1'b1;
            mem.address <= '0;
            mem.rd_en   <= 1'b0;
            mem.wr_en   <= 1'b0;
            mem.data_in <= '0;
            prot_err    <= 1'b0;
            tag1_v      <= 1'b0;
            tag1_owner  <= 1'b0;
            tag2_v      <= 1'b0;
            tag2_owner  <= 1'b0;
            p0.rvalid   <= 1'b0;
            p0.rdata    <= '0;
            p1.rvalid   <= 1'b0;
            p1.rdata    <= '0;
            arb_idle    <= 1'b1;
        end else begin
            if (any_gnt) begin
                last_gnt <= gnt1;
            end
            mem.rd_en <= issue_rd;
            mem.wr_en <= issue_wr;
            if (issue_rd || issue_wr) begin
                mem.address <= sel_addr;
            end
            if (issue_wr) begin
                mem.data_in <= sel_wdata;
            end
            if (blocked) begin
                prot_err <= 1'b1;
            end

            tag1_v     <= issue_rd;
            tag1_owner <= gnt1;
            tag2_v     <= tag1_v;
            tag2_owner <= tag1_owner;

            // Only the owner's rdata is refreshed; the other port keeps its last word.
            p0.rvalid <= tag2_v && !tag2_owner;
            p1.rvalid <= tag2_v && tag2_owner;
            if (tag2_v && !tag2_owner) begin
                p0.rdata <= mem.data_out;
            end
            if (tag2_v && tag2_owner) begin
                p1.rdata <= mem.data_out;
            end

            arb_idle <= !p0.req && !p1.req && !tag1_v && !tag2_v
                        && !mem.rd_en && !mem.wr_en;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-log model of the arbiter.

module tb_mem_port_arbiter;

    localparam int              AW    = 11;
    localparam int              DW    = 16;
    localparam logic [AW-1:0]   PROT  = 11'd1000;
    localparam int              NLOG  = 4096;
    localparam int              NWORD = 2048;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p0_bus ();
    mem_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) p1_bus ();
    mem_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();
    logic prot_err;
    logic arb_idle;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROT_BASE(PROT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .p0       (p0_bus),
        .p1       (p1_bus),
        .mem      (mem_bus),
        .prot_err (prot_err),
        .arb_idle (arb_idle)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 512) return 16'h1234;
        return DW'((i * 40503) ^ 23130);
    endfunction

    // ---------------- memory model (1-cycle read latency) ----------------
    logic [DW-1:0] mem_arr [NWORD];
    logic          mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < NWORD; i++) mem_arr[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (mem_bus.wr_en) mem_arr[mem_bus.address] <= mem_bus.data_in;
            if (mem_bus.rd_en) mem_bus.data_out <= mem_arr[mem_bus.address];
        end
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int pin_rd   = -100;
    int pin_ct   = -100;
    int pin_w1   = -100;
    int pin_pw   = -100;
    int pin_idle = -100;
    int pin_rrd  = -100;
    int pin_rlow = -100;
    int pin_rst  = -100;

    // Transaction log, one entry per cycle: who was granted what.
    logic          g_v    [NLOG];
    logic          g_port [NLOG];
    logic          g_we   [NLOG];
    logic          g_blk  [NLOG];
    logic [AW-1:0] g_addr [NLOG];
    logic [DW-1:0] g_wdat [NLOG];
    logic [DW-1:0] g_rdat [NLOG];
    logic          req_log[NLOG];
    logic [DW-1:0] model_mem [NWORD];

    logic          m_last;
    logic          m_prot;
    logic [DW-1:0] m_rd0;
    logic [DW-1:0] m_rd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic lv(input int i);
        return (i >= 0) ? g_v[i] : 1'b0;
    endfunction

    function automatic logic lread(input int i);
        return (i >= 0) ? (g_v[i] && !g_we[i]) : 1'b0;
    endfunction

    function automatic logic lcmd(input int i);
        return (i >= 0) ? (g_v[i] && (!g_we[i] || !g_blk[i])) : 1'b0;
    endfunction

    // ---------------- compare process ----------------
    initial begin : compare
        int            win;
        logic          r0, r1, e_rd, e_wr, rv0, rv1, e_idle;
        int            i1, i2, i3;
        for (int i = 0; i < NWORD; i++) model_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                chk("rst_gnt0", 32'(p0_bus.gnt), 32'd0);
                chk("rst_gnt1", 32'(p1_bus.gnt), 32'd0);
                chk("rst_rd_en", 32'(mem_bus.rd_en), 32'd0);
                chk("rst_wr_en", 32'(mem_bus.wr_en), 32'd0);
                chk("rst_addr", 32'(mem_bus.address), 32'd0);
                chk("rst_din", 32'(mem_bus.data_in), 32'd0);
                chk("rst_rvalid0", 32'(p0_bus.rvalid), 32'd0);
                chk("rst_rvalid1", 32'(p1_bus.rvalid), 32'd0);
                chk("rst_rdata0", 32'(p0_bus.rdata), 32'd0);
                chk("rst_rdata1", 32'(p1_bus.rdata), 32'd0);
                chk("rst_prot", 32'(prot_err), 32'd0);
                chk("rst_idle", 32'(arb_idle), 32'd1);
                if (cyc == pin_rlow) chk("pin_rlow_rd_en", 32'(mem_bus.rd_en), 32'd0);
                for (int i = 0; i < NLOG; i++) begin
                    g_v[i]     = 1'b0;
                    req_log[i] = 1'b0;
                end
                m_last = 1'b1;
                m_prot = 1'b0;
                m_rd0  = '0;
                m_rd1  = '0;
            end else begin
                r0 = p0_bus.req;
                r1 = p1_bus.req;
                req_log[cyc] = r0 | r1;
                win = -1;
                if (r0 && r1) win = m_last ? 0 : 1;
                else if (r0)  win = 0;
                else if (r1)  win = 1;
                chk("gnt0", 32'(p0_bus.gnt), 32'(win == 0));
                chk("gnt1", 32'(p1_bus.gnt), 32'(win == 1));

                i1 = cyc - 1;
                i2 = cyc - 2;
                i3 = cyc - 3;
                e_rd = lread(i1);
                e_wr = lv(i1) && g_we[i1] && !g_blk[i1];
                chk("rd_en", 32'(mem_bus.rd_en), 32'(e_rd));
                chk("wr_en", 32'(mem_bus.wr_en), 32'(e_wr));
                if (e_rd || e_wr) chk("address", 32'(mem_bus.address), 32'(g_addr[i1]));
                if (e_wr)         chk("data_in", 32'(mem_bus.data_in), 32'(g_wdat[i1]));

                rv0 = lread(i3) && !g_port[i3];
                rv1 = lread(i3) &&  g_port[i3];
                if (rv0) m_rd0 = g_rdat[i3];
                if (rv1) m_rd1 = g_rdat[i3];
                chk("rvalid0", 32'(p0_bus.rvalid), 32'(rv0));
                chk("rvalid1", 32'(p1_bus.rvalid), 32'(rv1));
                chk("rdata0", 32'(p0_bus.rdata), 32'(m_rd0));
                chk("rdata1", 32'(p1_bus.rdata), 32'(m_rd1));
                chk("prot_err", 32'(prot_err), 32'(m_prot));

                e_idle = !((i1 >= 0) && req_log[i1]) && !lcmd(i2) && !lread(i3);
                chk("arb_idle", 32'(arb_idle), 32'(e_idle));

                // Literal expectations that pin the model to hand-derived numbers.
                if (cyc == pin_rd)       chk("pin_p1rd_gnt", 32'(p1_bus.gnt), 32'd1);
                if (cyc == pin_rd + 1)   chk("pin_p1rd_rd_en", 32'(mem_bus.rd_en), 32'd1);
                if (cyc == pin_rd + 1)   chk("pin_p1rd_addr", 32'(mem_bus.address), 32'd512);
                if (cyc == pin_rd + 3)   chk("pin_p1rd_rvalid", 32'(p1_bus.rvalid), 32'd1);
                if (cyc == pin_rd + 3)   chk("pin_p1rd_rdata", 32'(p1_bus.rdata), 32'h1234);
                if (cyc == pin_rd + 3)   chk("pin_p1rd_p0rv", 32'(p0_bus.rvalid), 32'd0);
                if (cyc == pin_ct)       chk("pin_ct_g0", 32'(p0_bus.gnt), 32'd1);
                if (cyc == pin_ct + 1)   chk("pin_ct_g1", 32'(p1_bus.gnt), 32'd1);
                if (cyc == pin_ct + 2)   chk("pin_ct_g0b", 32'(p0_bus.gnt), 32'd1);
                if (cyc == pin_ct + 3)   chk("pin_ct_g1b", 32'(p1_bus.gnt), 32'd1);
                if (cyc == pin_ct + 3)   chk("pin_ct_rv0", 32'(p0_bus.rvalid), 32'd1);
                if (cyc == pin_ct + 4)   chk("pin_ct_rv1", 32'(p1_bus.rvalid), 32'd1);
                if (cyc == pin_w1 + 1)   chk("pin_w1_wr_en", 32'(mem_bus.wr_en), 32'd1);
                if (cyc == pin_w1 + 1)   chk("pin_w1_addr", 32'(mem_bus.address), 32'd1000);
                if (cyc == pin_w1 + 1)   chk("pin_w1_data", 32'(mem_bus.data_in), 32'h0003);
                if (cyc == pin_w1 + 1)   chk("pin_w1_prot", 32'(prot_err), 32'd0);
                if (cyc == pin_pw)       chk("pin_pw_gnt", 32'(p0_bus.gnt), 32'd1);
                if (cyc == pin_pw + 1)   chk("pin_pw_wr_en", 32'(mem_bus.wr_en), 32'd0);
                if (cyc == pin_pw + 1)   chk("pin_pw_prot", 32'(prot_err), 32'd1);
                if (cyc == pin_pw + 21)  chk("pin_pw_prot_held", 32'(prot_err), 32'd1);
                if (cyc == pin_idle)     chk("pin_idle_g1", 32'(p1_bus.gnt), 32'd1);
                if (cyc == pin_idle)     chk("pin_idle_g0", 32'(p0_bus.gnt), 32'd0);
                if (cyc == pin_rrd + 3)  chk("pin_rrd_no_rv", 32'(p1_bus.rvalid), 32'd0);
                if (cyc == pin_rst)      chk("pin_rst_g0", 32'(p0_bus.gnt), 32'd1);
                if (cyc == pin_rst)      chk("pin_rst_g1", 32'(p1_bus.gnt), 32'd0);

                if (win >= 0) begin
                    g_v[cyc]    = 1'b1;
                    g_port[cyc] = (win == 1);
                    g_we[cyc]   = (win == 0) ? p0_bus.we    : p1_bus.we;
                    g_addr[cyc] = (win == 0) ? p0_bus.addr  : p1_bus.addr;
                    g_wdat[cyc] = (win == 0) ? p0_bus.wdata : p1_bus.wdata;
                    g_blk[cyc]  = (win == 0) && g_we[cyc] && (g_addr[cyc] >= PROT);
                    if (!g_we[cyc]) g_rdat[cyc] = model_mem[g_addr[cyc]];
                    else if (!g_blk[cyc]) model_mem[g_addr[cyc]] = g_wdat[cyc];
                    if (g_blk[cyc]) m_prot = 1'b1;
                    m_last = (win == 1);
                end else begin
                    g_v[cyc] = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            p0_bus.req = req; p0_bus.we = we; p0_bus.addr = addr; p0_bus.wdata = wdata;
        end else begin
            p1_bus.req = req; p1_bus.we = we; p1_bus.addr = addr; p1_bus.wdata = wdata;
        end
    endtask

    task automatic idle(input int n);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_cmd(input int port);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(990, 1010))
                                        : AW'($urandom_range(0, NWORD - 1));
        drive(port, ($urandom_range(0, 3) != 0), 1'(($urandom_range(0, 1))), a,
              DW'($urandom()));
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic g0, g1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        idle(3);

        // Single port-1 read of the preloaded word.
        drive(1, 1'b1, 1'b0, 11'd512, '0);
        pin_rd = cyc + 1;
        step();
        idle(5);

        // Continuous two-port read contest.
        drive(0, 1'b1, 1'b0, 11'd5, '0);
        drive(1, 1'b1, 1'b0, 11'd513, '0);
        pin_ct = cyc + 1;
        repeat (4) step();
        idle(5);

        // Port 1 writes into the results region freely.
        drive(1, 1'b1, 1'b1, 11'd1000, 16'h0003);
        pin_w1 = cyc + 1;
        step();
        idle(4);

        // Port 0 write into the results region is swallowed and flagged.
        drive(0, 1'b1, 1'b1, 11'd1000, 16'hFFFF);
        pin_pw = cyc + 1;
        step();
        idle(22);

        // After idling, port 1 must win because port 0 won last.
        drive(0, 1'b1, 1'b0, 11'd7, '0);
        drive(1, 1'b1, 1'b0, 11'd1000, '0);
        pin_idle = cyc + 1;
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
        idle(5);

        // Reset lands while a read is in flight.
        drive(1, 1'b1, 1'b0, 11'd512, '0);
        pin_rrd = cyc + 1;
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        reset_n  = 1'b0;
        pin_rlow = cyc + 1;
        step();
        reset_n = 1'b1;
        idle(3);
        drive(0, 1'b1, 1'b0, 11'd9, '0);
        drive(1, 1'b1, 1'b0, 11'd10, '0);
        pin_rst = cyc + 1;
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        idle(5);

        // Random traffic; an ungranted command is held unchanged.
        rand_cmd(0);
        rand_cmd(1);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            g0 = p0_bus.gnt;
            g1 = p1_bus.gnt;
            step();
            if (!p0_bus.req || g0) rand_cmd(0);
            if (!p1_bus.req || g1) rand_cmd(1);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
